dff_bank_arbiter: RTL and testbench

Arbitrates two requesters sharing one WIDTH-bit D-flip-flop register bank, sequencing each write through a one-cycle grant handshake. Provides synchronous active-low set/clear overrides on the bank and counts committed writes. Sits between the stimulus/requester logic and the latch/flip-flop bank in the lab datapath.

---
 rtl/dff_bank_arbiter.sv | 108 ++++++++++
 tb/tb_dff_bank_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dff_bank_arbiter.sv
// Two-requester arbiter in front of a WIDTH-bit flip-flop bank with active-low set/clear overrides and a committed-write counter.
// Optional macro ARB_FIXED_PRI_EN: requester 0 always wins contention (no round-robin pointer).
module dff_bank_arbiter #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             CP,
   input  logic             RST,
   input  logic             REQ0,
   input  logic [WIDTH-1:0] D0,
   input  logic             REQ1,
   input  logic [WIDTH-1:0] D1,
   input  logic             SET_N,
   input  logic             CLR_N,
   output logic             GNT0,
   output logic             GNT1,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] NQ,
   output logic             BUSY,
   output logic             DROP,
   output logic [CNT_W-1:0] WR_CNT
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR0  = 2'd1,
      WR1  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] q_r, q_nxt;
   logic             drop_r, drop_nxt;
   logic [CNT_W-1:0] cnt_r, cnt_nxt;
   state_t           contend_pick;

`ifdef ARB_FIXED_PRI_EN
   assign contend_pick = WR0;
`else
   logic ptr, ptr_nxt;
   assign contend_pick = ptr ? WR1 : WR0;
`endif

   always_ff @(posedge CP or posedge RST) begin
      if (RST) begin
         state  <= IDLE;
         q_r    <= '0;
         drop_r <= 1'b0;
         cnt_r  <= '0;
`ifndef ARB_FIXED_PRI_EN
         ptr    <= 1'b0;
`endif
      end else begin
         state  <= state_nxt;
         q_r    <= q_nxt;
         drop_r <= drop_nxt;
         cnt_r  <= cnt_nxt;
`ifndef ARB_FIXED_PRI_EN
         ptr    <= ptr_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      q_nxt     = q_r;
      drop_nxt  = 1'b0;
      cnt_nxt   = cnt_r;
`ifndef ARB_FIXED_PRI_EN
      ptr_nxt   = ptr;
`endif
      case (state)
         IDLE: begin
            if (!CLR_N)      q_nxt = '0;
            else if (!SET_N) q_nxt = '1;
            if (REQ0 && REQ1) state_nxt = contend_pick;
            else if (REQ0)    state_nxt = WR0;
            else if (REQ1)    state_nxt = WR1;
         end
         WR0, WR1: begin
            state_nxt = IDLE;
`ifndef ARB_FIXED_PRI_EN
            // grant is consumed whether committed or dropped
            ptr_nxt   = (state == WR0);
`endif
            if (!CLR_N) begin
               q_nxt    = '0;
               drop_nxt = 1'b1;
            end else if (!SET_N) begin
               q_nxt    = '1;
               drop_nxt = 1'b1;
            end else begin
               q_nxt   = (state == WR0) ? D0 : D1;
               cnt_nxt = cnt_r + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign GNT0   = (state == WR0);
   assign GNT1   = (state == WR1);
   assign BUSY   = GNT0 | GNT1;
   assign Q      = q_r;
   assign NQ     = ~q_r;
   assign DROP   = drop_r;
   assign WR_CNT = cnt_r;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed self-checking bench for dff_bank_arbiter; outputs sampled 1 time unit after each rising edge.
module tb_dff_bank_arbiter;

   logic       CP = 1'b0;
   logic       RST, REQ0, REQ1, SET_N, CLR_N;
   logic [3:0] D0, D1;
   logic       GNT0, GNT1, BUSY, DROP;
   logic [3:0] Q, NQ;
   logic [7:0] WR_CNT;

   int vectors     = 0;
   int miscompares = 0;

   dff_bank_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
      .CP(CP), .RST(RST), .REQ0(REQ0), .D0(D0), .REQ1(REQ1), .D1(D1),
      .SET_N(SET_N), .CLR_N(CLR_N), .GNT0(GNT0), .GNT1(GNT1), .Q(Q), .NQ(NQ),
      .BUSY(BUSY), .DROP(DROP), .WR_CNT(WR_CNT)
   );

   always #5 CP = ~CP;

   task automatic step();
      @(posedge CP);
      #1;
   endtask

   task automatic pulse_reset();
      RST = 1'b1;
      #2;
      RST = 1'b0;
      step();
   endtask

   task automatic test_reset();
      RST = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0; SET_N = 1'b1; CLR_N = 1'b1; D0 = '0; D1 = '0;
      step(); step();
      RST = 1'b0;
      step();
      REQ0 = 1'b1; D0 = 4'b0101;
      step();
      REQ0 = 1'b0;
      step();
      vectors++; if (WR_CNT !== 8'd1) begin miscompares++; $display("FAIL pre_reset_cnt: got %0d expected 1", WR_CNT); end
      REQ0 = 1'b1; D0 = 4'b0110;
      step();
      vectors++; if (GNT0 !== 1'b1) begin miscompares++; $display("FAIL pre_reset_gnt0: got %b expected 1", GNT0); end
      // asynchronous reset mid-grant, checked before any clock edge
      RST = 1'b1;
      #2;
      vectors++; if (Q !== 4'b0000) begin miscompares++; $display("FAIL reset_q: got %b expected 0000", Q); end
      vectors++; if (NQ !== 4'b1111) begin miscompares++; $display("FAIL reset_nq: got %b expected 1111", NQ); end
      vectors++; if ({GNT0, GNT1, BUSY, DROP} !== 4'b0000) begin miscompares++; $display("FAIL reset_ctl: got %b expected 0000", {GNT0, GNT1, BUSY, DROP}); end
      vectors++; if (WR_CNT !== 8'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d expected 0", WR_CNT); end
      REQ0 = 1'b0;
      RST = 1'b0;
      step();
      vectors++; if ({GNT0, Q, WR_CNT} !== 13'd0) begin miscompares++; $display("FAIL reset_hold: got %h expected 0", {GNT0, Q, WR_CNT}); end
   endtask

   task automatic test_single_write();
      REQ0 = 1'b1; D0 = 4'b1010;
      step();
      vectors++; if ({GNT0, GNT1, BUSY} !== 3'b101) begin miscompares++; $display("FAIL single_gnt: got %b expected 101", {GNT0, GNT1, BUSY}); end
      vectors++; if (Q !== 4'b0000) begin miscompares++; $display("FAIL single_q_early: got %b expected 0000", Q); end
      REQ0 = 1'b0;
      step();
      vectors++; if (Q !== 4'b1010) begin miscompares++; $display("FAIL single_q: got %b expected 1010", Q); end
      vectors++; if (NQ !== 4'b0101) begin miscompares++; $display("FAIL single_nq: got %b expected 0101", NQ); end
      vectors++; if ({GNT0, BUSY, DROP} !== 3'b000) begin miscompares++; $display("FAIL single_ctl: got %b expected 000", {GNT0, BUSY, DROP}); end
      vectors++; if (WR_CNT !== 8'd1) begin miscompares++; $display("FAIL single_cnt: got %0d expected 1", WR_CNT); end
      step();
      vectors++; if (GNT0 !== 1'b0) begin miscompares++; $display("FAIL single_gnt_once: got %b expected 0", GNT0); end
   endtask

   task automatic test_contention();
      logic [5:0] e_g0, e_g1;
      logic [3:0] e_q [6];
      pulse_reset();
`ifdef ARB_FIXED_PRI_EN
      e_g0 = 6'b010101; e_g1 = 6'b000000;
      e_q  = '{4'h0, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3};
`else
      e_g0 = 6'b010001; e_g1 = 6'b000100;
      e_q  = '{4'h0, 4'h3, 4'h3, 4'hC, 4'hC, 4'h3};
`endif
      REQ0 = 1'b1; REQ1 = 1'b1; D0 = 4'b0011; D1 = 4'b1100;
      for (int i = 0; i < 6; i++) begin
         step();
         vectors++; if ({GNT0, GNT1} !== {e_g0[i], e_g1[i]}) begin miscompares++; $display("FAIL contend_gnt[%0d]: got %b expected %b", i, {GNT0, GNT1}, {e_g0[i], e_g1[i]}); end
         vectors++; if (Q !== e_q[i]) begin miscompares++; $display("FAIL contend_q[%0d]: got %b expected %b", i, Q, e_q[i]); end
      end
      REQ0 = 1'b0; REQ1 = 1'b0;
      step();
      vectors++; if (WR_CNT !== 8'd3) begin miscompares++; $display("FAIL contend_cnt: got %0d expected 3", WR_CNT); end
   endtask

   task automatic test_override_grant();
      REQ1 = 1'b1; D1 = 4'b1111;
      step();
      vectors++; if (GNT1 !== 1'b1) begin miscompares++; $display("FAIL ovr_gnt1: got %b expected 1", GNT1); end
      REQ1 = 1'b0; CLR_N = 1'b0;
      step();
      vectors++; if (Q !== 4'b0000) begin miscompares++; $display("FAIL ovr_clr_q: got %b expected 0000", Q); end
      vectors++; if ({DROP, GNT1} !== 2'b10) begin miscompares++; $display("FAIL ovr_clr_drop: got %b expected 10", {DROP, GNT1}); end
      vectors++; if (WR_CNT !== 8'd3) begin miscompares++; $display("FAIL ovr_clr_cnt: got %0d expected 3", WR_CNT); end
      CLR_N = 1'b1;
      step();
      vectors++; if (DROP !== 1'b0) begin miscompares++; $display("FAIL ovr_drop_once: got %b expected 0", DROP); end
      REQ0 = 1'b1; REQ1 = 1'b1; D0 = 4'b0011; D1 = 4'b1100;
      step();
      vectors++; if ({GNT0, GNT1} !== 2'b10) begin miscompares++; $display("FAIL ovr_next_gnt: got %b expected 10", {GNT0, GNT1}); end
      REQ0 = 1'b0; REQ1 = 1'b0;
      step();
      vectors++; if ({Q, WR_CNT} !== {4'b0011, 8'd4}) begin miscompares++; $display("FAIL ovr_next_write: got %h expected 304", {Q, WR_CNT}); end
      REQ1 = 1'b1; D1 = 4'b0101;
      step();
      REQ1 = 1'b0; SET_N = 1'b0;
      step();
      vectors++; if ({Q, DROP, WR_CNT} !== {4'b1111, 1'b1, 8'd4}) begin miscompares++; $display("FAIL ovr_set_drop: got %h expected %h", {Q, DROP, WR_CNT}, {4'b1111, 1'b1, 8'd4}); end
      SET_N = 1'b1;
      step();
      vectors++; if ({Q, DROP} !== 5'b11110) begin miscompares++; $display("FAIL ovr_set_after: got %b expected 11110", {Q, DROP}); end
   endtask

   task automatic test_override_idle();
      SET_N = 1'b0; CLR_N = 1'b0;
      step();
      vectors++; if ({Q, DROP, BUSY} !== 6'b000000) begin miscompares++; $display("FAIL idle_both: got %b expected 000000", {Q, DROP, BUSY}); end
      CLR_N = 1'b1;
      step();
      vectors++; if ({Q, NQ} !== 8'b11110000) begin miscompares++; $display("FAIL idle_set: got %b expected 11110000", {Q, NQ}); end
      SET_N = 1'b1;
      step();
      vectors++; if ({Q, DROP, WR_CNT} !== {4'b1111, 1'b0, 8'd4}) begin miscompares++; $display("FAIL idle_hold: got %h expected %h", {Q, DROP, WR_CNT}, {4'b1111, 1'b0, 8'd4}); end
   endtask

   task automatic test_counter_wrap();
      pulse_reset();
      REQ0 = 1'b1; D0 = 4'b0110;
      for (int i = 0; i < 255; i++) begin
         step(); step();
      end
      vectors++; if (WR_CNT !== 8'd255) begin miscompares++; $display("FAIL wrap_255: got %0d expected 255", WR_CNT); end
      step(); step();
      vectors++; if (WR_CNT !== 8'd0) begin miscompares++; $display("FAIL wrap_0: got %0d expected 0", WR_CNT); end
      vectors++; if (Q !== 4'b0110) begin miscompares++; $display("FAIL wrap_q: got %b expected 0110", Q); end
      REQ0 = 1'b0;
      step();
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_contention();
      test_override_grant();
      test_override_idle();
      test_counter_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
